// File: rtl/rf_wb_arbiter.sv
// Register file write-port arbiter: pipeline writeback has fixed priority, long-latency
// results queue in a small FIFO, and a pending-write scoreboard lets decode detect hazards.
module rf_wb_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        mdu_valid,
  output logic        mdu_ready,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_data,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  output logic        iss_ready,
  input  logic [4:0]  chk_rs1,
  input  logic [4:0]  chk_rs2,
  input  logic [4:0]  chk_rd,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic        rd_busy,
  output logic        stall_req,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [SW-1:0] LIMIT      = SW'(STARVE_LIMIT);

  logic [4:0]    fifo_rd   [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          empty, full, push, pop;
  logic [4:0]    head_rd;
  logic [31:0]   head_data;
  logic [31:0]   busy, busy_next;
  logic [SW-1:0] starve_cnt, starve_next;

  assign empty     = (count == '0);
  assign full      = (count == FULL_COUNT);
  assign mdu_ready = !full;
  assign push      = mdu_valid && mdu_ready;
  assign pop       = !wb_valid && !empty;
  assign head_rd   = fifo_rd[rptr];
  assign head_data = fifo_data[rptr];

  always_comb begin
    rf_wen   = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (wb_valid) begin
      rf_waddr = wb_rd;
      rf_wdata = wb_data;
      rf_wen   = (wb_rd != 5'd0);
    end else if (!empty) begin
      rf_waddr = head_rd;
      rf_wdata = head_data;
      rf_wen   = (head_rd != 5'd0);
    end
  end

  // Storage needs no reset: an entry is only read once count says it was written.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wptr]   <= mdu_rd;
      fifo_data[wptr] <= mdu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Bit 0 is kept permanently clear so lookups of x0 always report not-busy.
  assign iss_ready = (iss_rd == 5'd0) || !busy[iss_rd];
  assign rs1_busy  = busy[chk_rs1];
  assign rs2_busy  = busy[chk_rs2];
  assign rd_busy   = busy[chk_rd];

  always_comb begin
    busy_next = busy;
    if (pop && head_rd != 5'd0)
      busy_next[head_rd] = 1'b0;
    if (iss_valid && iss_ready && iss_rd != 5'd0)
      busy_next[iss_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_next;
  end

  always_comb begin
    starve_next = starve_cnt;
    if (empty || pop)
      starve_next = '0;
    else if (wb_valid && starve_cnt < LIMIT)
      starve_next = starve_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      stall_req  <= 1'b0;
    end else begin
      starve_cnt <= starve_next;
      stall_req  <= (starve_next >= LIMIT);
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: expected register-file writes are queued by the
// stimulus and popped by an independent monitor; status outputs are checked inline.
`timescale 1ns/100ps
module tb_rf_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_ready;
  logic [4:0]  chk_rs1, chk_rs2, chk_rd;
  logic        rs1_busy, rs2_busy, rd_busy;
  logic        stall_req;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int tests_run = 0;
  int fails     = 0;
  logic [36:0] exp_q[$];

  rf_wb_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rd_busy(rd_busy),
    .stall_req(stall_req),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #0.1;
  endtask

  task automatic applyStimulus(input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                               input logic mv, input logic [4:0] mr, input logic [31:0] md,
                               input logic iv, input logic [4:0] ir);
    wb_valid  = wv;
    wb_rd     = wr;
    wb_data   = wd;
    mdu_valid = mv;
    mdu_rd    = mr;
    mdu_data  = md;
    iss_valid = iv;
    iss_rd    = ir;
    settle();
  endtask

  task automatic expectWrite(input logic [4:0] addr, input logic [31:0] data);
    exp_q.push_back({addr, data});
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Monitor: every enabled write must match the oldest expected write.
  always @(negedge clk) begin
    logic [36:0] e;
    if (!rst && rf_wen) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("[TB] FAIL unexpected_write: got addr=%0d data=%h, required no write",
                 rf_waddr, rf_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({rf_waddr, rf_wdata} !== e) begin
          fails++;
          $display("[TB] FAIL rf_write: got addr=%0d data=%h, required addr=%0d data=%h",
                   rf_waddr, rf_wdata, e[36:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    chk_rs1 = '0; chk_rs2 = '0; chk_rd = '0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    rst = 1'b0;

    // Fill FIFO and scoreboard while WB (to x0) blocks the port, then reset mid-operation
    applyStimulus(1, 0, 32'h1, 1, 3, 32'h33, 1, 3); tick();
    applyStimulus(1, 0, 32'h1, 1, 4, 32'h44, 1, 4); tick();
    applyStimulus(1, 0, 32'h1, 0, 0, 0, 0, 0);
    checkOutput("pre_reset_full_ready", mdu_ready, 0);
    chk_rs1 = 3; settle();
    checkOutput("pre_reset_busy3", rs1_busy, 1);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("reset_rf_wen", rf_wen, 0);
    checkOutput("reset_mdu_ready", mdu_ready, 1);
    checkOutput("reset_stall_req", stall_req, 0);
    for (int i = 0; i < 32; i++) begin
      chk_rs1 = 5'(i); settle();
      checkOutput($sformatf("reset_rs1_busy_%0d", i), rs1_busy, 0);
    end

    // Priority: WB beats the FIFO head; head written once WB drops
    applyStimulus(0, 0, 0, 1, 7, 32'h1234, 1, 7);
    checkOutput("no_bypass_wen", rf_wen, 0);
    tick();
    applyStimulus(1, 5, 32'hAAAA0000, 0, 0, 0, 0, 0);
    expectWrite(5, 32'hAAAA0000);
    checkOutput("wb_wins_addr", rf_waddr, 5);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    expectWrite(7, 32'h1234);
    chk_rs1 = 7; settle();
    checkOutput("busy7_during_pop", rs1_busy, 1);
    tick();
    checkOutput("busy7_cleared", rs1_busy, 0);
    checkOutput("idle_wen", rf_wen, 0);

    // Full FIFO: third result held until a pop has taken effect
    applyStimulus(1, 0, 0, 1, 8, 32'h88, 0, 0); tick();
    applyStimulus(1, 0, 0, 1, 9, 32'h99, 0, 0); tick();
    applyStimulus(1, 0, 0, 1, 10, 32'hAA, 0, 0);
    checkOutput("full_ready", mdu_ready, 0);
    tick();
    checkOutput("full_held_ready", mdu_ready, 0);
    applyStimulus(0, 0, 0, 1, 10, 32'hAA, 0, 0);
    expectWrite(8, 32'h88);
    checkOutput("pop_cycle_ready", mdu_ready, 0);
    tick();
    applyStimulus(1, 0, 0, 1, 10, 32'hAA, 0, 0);
    checkOutput("ready_after_pop", mdu_ready, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    expectWrite(9, 32'h99);
    tick();
    expectWrite(10, 32'hAA);
    tick();
    checkOutput("fifo_drained_wen", rf_wen, 0);
    checkOutput("fifo_drained_ready", mdu_ready, 1);

    // Starvation: one entry blocked by continuous WB
    applyStimulus(1, 0, 0, 1, 11, 32'hB0B, 0, 0); tick();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      checkOutput($sformatf("starve_low_%0d", i), stall_req, 0);
      tick();
    end
    checkOutput("starve_high", stall_req, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    expectWrite(11, 32'hB0B);
    tick();
    checkOutput("starve_release", stall_req, 0);

    // Scoreboard: issue x10, block a second issue, release after commit
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 10);
    checkOutput("iss_ready_free", iss_ready, 1);
    tick();
    applyStimulus(0, 0, 0, 1, 10, 32'hC0DE, 1, 10);
    chk_rs1 = 10; chk_rs2 = 11; chk_rd = 10; settle();
    checkOutput("rs1_busy_x10", rs1_busy, 1);
    checkOutput("rs2_busy_x11", rs2_busy, 0);
    checkOutput("rd_busy_x10", rd_busy, 1);
    checkOutput("iss_ready_blocked", iss_ready, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 10);
    expectWrite(10, 32'hC0DE);
    checkOutput("iss_ready_same_cycle_clear", iss_ready, 0);
    tick();
    checkOutput("iss_ready_after_commit", iss_ready, 1);
    checkOutput("rs1_busy_after_commit", rs1_busy, 0);

    // x0: issue and result to x0 leave no bit, pop proceeds silently
    applyStimulus(0, 0, 0, 1, 0, 32'hDEAD, 1, 0);
    checkOutput("iss_ready_x0", iss_ready, 1);
    tick();
    applyStimulus(0, 0, 0, 1, 12, 32'h1212, 0, 0);
    checkOutput("x0_pop_wen", rf_wen, 0);
    for (int i = 0; i < 32; i++) begin
      chk_rs2 = 5'(i); settle();
      checkOutput($sformatf("x0_rs2_busy_%0d", i), rs2_busy, 0);
    end
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    expectWrite(12, 32'h1212);
    tick();
    checkOutput("idle_after_x0", rf_wen, 0);
    tick();
    checkOutput("queue_drained", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
